// File: rtl/plot_framebuffer.sv
// plot_framebuffer: 160x120x3 pixel store fed by plot/x/y/colour, with point queries, raster scan-out and full clear.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   plot, x, y, colour         pixel write strobe and data
//   clear_req, busy            start a full-screen clear / clear in progress
//   drop_count                 plots lost while clearing, saturating
//   rd_req, rd_x, rd_y         colour query; result one cycle later on rd_valid/rd_colour
//   scan_en                    advances the raster scan when the read port is free
//   scan_valid, scan_x, scan_y, scan_colour, frame_done   scanned pixel stream
module plot_framebuffer #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] drop_count,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  input  logic       scan_en,
  output logic       scan_valid,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       frame_done
);
  localparam int          DEPTH = WIDTH * HEIGHT;
  localparam logic [14:0] LAST  = 15'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t      state, state_nx;
  logic [14:0] clr_addr, clr_addr_nx, plot_addr, rd_addr, scan_addr, raddr, waddr;
  logic [2:0]  mem [DEPTH];
  logic [2:0]  mem_q, rd_hold, wdata;
  logic [7:0]  sx;
  logic [6:0]  sy;
  logic        plot_in, rd_in, rd_oob_q, scan_go, last_x, last_y, we;
  always_comb begin
    plot_in     = x < 8'(WIDTH) && y < 7'(HEIGHT);
    rd_in       = rd_x < 8'(WIDTH) && rd_y < 7'(HEIGHT);
    plot_addr   = 15'(y) * 15'(WIDTH) + 15'(x);
    rd_addr     = rd_in ? 15'(rd_y) * 15'(WIDTH) + 15'(rd_x) : '0;
    scan_addr   = 15'(sy) * 15'(WIDTH) + 15'(sx);
    scan_go     = scan_en && !rd_req;
    raddr       = rd_req ? rd_addr : scan_addr;
    last_x      = sx == 8'(WIDTH - 1);
    last_y      = sy == 7'(HEIGHT - 1);
    busy        = state == CLEAR;
    we          = busy || (plot && plot_in);
    waddr       = busy ? clr_addr : plot_addr;
    wdata       = busy ? CLEAR_COLOUR : colour;
    state_nx    = busy ? (clr_addr == LAST ? RUN : CLEAR) : (clear_req ? CLEAR : RUN);
    clr_addr_nx = (busy && clr_addr != LAST) ? clr_addr + 15'd1 : '0;
    rd_colour   = rd_valid ? (rd_oob_q ? CLEAR_COLOUR : mem_q) : rd_hold;
    scan_colour = scan_valid ? mem_q : '0;
  end
  // Non-blocking write alongside the read gives read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    mem_q <= mem[raddr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      drop_count <= '0;
      rd_valid   <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_hold    <= '0;
      sx         <= '0;
      sy         <= '0;
      scan_valid <= 1'b0;
      scan_x     <= '0;
      scan_y     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_addr   <= clr_addr_nx;
      if (busy && plot && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      rd_valid   <= rd_req;
      if (rd_req) rd_oob_q <= !rd_in;
      if (rd_valid) rd_hold <= rd_colour;
      scan_valid <= scan_go;
      frame_done <= scan_go && last_x && last_y;
      if (scan_go) begin
        scan_x <= sx;
        scan_y <= sy;
        sx     <= last_x ? '0 : sx + 8'd1;
        if (last_x) sy <= last_y ? '0 : sy + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_plot_framebuffer.sv
// tb_plot_framebuffer: directed vector and sequence checks for plot_framebuffer.
module tb_plot_framebuffer;
  logic       clk = 0, reset_n = 0, plot = 0, clear_req = 0, rd_req = 0, scan_en = 0;
  logic [7:0] x = 0, rd_x = 0;
  logic [6:0] y = 0, rd_y = 0;
  logic [2:0] colour = 0;
  logic       busy, rd_valid, scan_valid, frame_done;
  logic [7:0] drop_count, scan_x;
  logic [6:0] scan_y;
  logic [2:0] rd_colour, scan_colour;
  int         n_chk = 0, n_pass = 0, ex = 0, ey = 0;
  logic [2:0] model [19200];
  typedef struct {
    logic p; int x, y, c;
    logic r; int rx, ry;
    logic ev; int ec;
  } vec_t;
  vec_t v [14];
  plot_framebuffer dut (
    .clk(clk), .reset_n(reset_n), .plot(plot), .x(x), .y(y), .colour(colour),
    .clear_req(clear_req), .busy(busy), .drop_count(drop_count),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_colour(rd_colour),
    .scan_en(scan_en), .scan_valid(scan_valid), .scan_x(scan_x), .scan_y(scan_y),
    .scan_colour(scan_colour), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int addr(input int px, input int py);
    return py * 160 + px;
  endfunction
  task automatic check_pix(input string tag);
    logic [19:0] act, exp;
    act = {scan_valid, scan_x, scan_y, scan_colour, frame_done};
    exp = {1'b1, 8'(ex), 7'(ey), model[addr(ex, ey)], 1'(ex == 159 && ey == 119)};
    check($sformatf("%s(%0d,%0d)", tag, ex, ey), int'(act), int'(exp));
    if (ex == 159) begin
      ex = 0;
      ey = (ey == 119) ? 0 : ey + 1;
    end else ex++;
  endtask
  initial begin
    int n;
    int qp [5][2];
    int pp [6][3];
    v[0]  = '{1, 10, 20, 4,   1, 5, 5,     1, 0};
    v[1]  = '{0, 0, 0, 0,     1, 10, 20,   1, 4};
    v[2]  = '{1, 10, 20, 2,   1, 10, 20,   1, 4};
    v[3]  = '{0, 0, 0, 0,     1, 10, 20,   1, 2};
    v[4]  = '{1, 160, 0, 7,   1, 0, 0,     1, 0};
    v[5]  = '{1, 0, 120, 7,   1, 0, 1,     1, 0};
    v[6]  = '{1, 0, 1, 5,     0, 0, 0,     0, 0};
    v[7]  = '{0, 0, 0, 0,     1, 160, 0,   1, 0};
    v[8]  = '{0, 0, 0, 0,     1, 0, 1,     1, 5};
    v[9]  = '{1, 159, 119, 6, 0, 0, 0,     0, 5};
    v[10] = '{0, 0, 0, 0,     1, 159, 119, 1, 6};
    v[11] = '{1, 255, 127, 3, 1, 159, 119, 1, 6};
    v[12] = '{0, 0, 0, 0,     1, 0, 120,   1, 0};
    v[13] = '{0, 0, 0, 0,     0, 0, 0,     0, 0};
    qp = '{'{10, 20}, '{0, 1}, '{159, 119}, '{20, 20}, '{0, 0}};
    pp = '{'{0, 0, 1}, '{159, 0, 2}, '{0, 119, 3}, '{159, 119, 7}, '{80, 60, 5}, '{1, 0, 4}};
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    #2;
    check("rst_busy", busy, 1);
    check("rst_drop", drop_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_colour", rd_colour, 0);
    check("rst_scan", int'({scan_valid, scan_x, scan_y, scan_colour, frame_done}), 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    check("busy_after_release", busy, 1);
    n = 0;
    while (busy && n < 30000) begin
      tick;
      n++;
    end
    check("init_clear_cycles", n, 19200);
    for (int i = 0; i < 14; i++) begin
      plot = v[i].p; x = 8'(v[i].x); y = 7'(v[i].y); colour = 3'(v[i].c);
      rd_req = v[i].r; rd_x = 8'(v[i].rx); rd_y = 7'(v[i].ry);
      tick;
      check($sformatf("vec%0d_rd_valid", i), rd_valid, v[i].ev);
      check($sformatf("vec%0d_rd_colour", i), rd_colour, v[i].ec);
      check($sformatf("vec%0d_drop", i), drop_count, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end
    plot = 0; rd_req = 0;
    plot = 1; x = 20; y = 20; colour = 7; clear_req = 1;
    tick;
    clear_req = 0;
    check("clear_busy", busy, 1);
    n = 0;
    while (busy && n < 30000) begin
      plot = n < 300;
      x = (n % 2 == 1) ? 8'd200 : 8'(n % 160);
      y = 7'd8;
      clear_req = n == 1000;
      tick;
      n++;
      if (n == 100) check("drop_mid", drop_count, 100);
    end
    plot = 0; clear_req = 0;
    check("clear_cycles", n, 19200);
    check("drop_sat", drop_count, 255);
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      rd_req = 1; rd_x = 8'(qp[i][0]); rd_y = 7'(qp[i][1]);
      tick;
      check($sformatf("post_clear_q%0d", i), int'({rd_valid, rd_colour}), 8);
    end
    rd_req = 0;
    for (int i = 0; i < 6; i++) begin
      plot = 1; x = 8'(pp[i][0]); y = 7'(pp[i][1]); colour = 3'(pp[i][2]);
      model[addr(pp[i][0], pp[i][1])] = 3'(pp[i][2]);
      tick;
    end
    plot = 0;
    check("drop_hold", drop_count, 255);
    ex = 0; ey = 0;
    scan_en = 1;
    for (int i = 0; i < 19201; i++) begin
      tick;
      check_pix("scan");
    end
    for (int i = 0; i < 300; i++) begin
      rd_req = (i % 3 == 2); rd_x = 0; rd_y = 0;
      tick;
      if (rd_req) begin
        check("gap_scan_valid", scan_valid, 0);
        check("gap_rd_colour", rd_colour, model[0]);
      end else check_pix("scan3");
    end
    rd_req = 0;
    #2;
    reset_n = 0;
    #1;
    check("midscan_rst", int'({scan_valid, scan_x, scan_y, frame_done}), 0);
    check("midscan_rst_busy", busy, 1);
    @(negedge clk);
    reset_n = 1;
    ex = 0; ey = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_pix("restart");
    end
    scan_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
